// File: rtl/ddr2_arb_pkg.sv
// Shared types and defaults for the DDR2 write arbiter slice.
package ddr2_arb_pkg;

   localparam int ADDR_W_DEF = 31;
   localparam int DATA_W_DEF = 128;
   localparam int MASK_W_DEF = 16;

   // Idle byte mask: every byte masked off, so a stray write would be harmless
   localparam logic [MASK_W_DEF-1:0] MASK_ALL = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT1 = 2'd1,
      BEAT2 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/ddr2_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to prio.
module ddr2_arb_rr (
   input  logic [1:0] req,
   input  logic       prio,
   output logic [1:0] pick
);

   // One-hot pick from the request pair and the favoured port
   always_comb begin
      pick = 2'b00;
      case (req)
         2'b01:   pick = 2'b01;
         2'b10:   pick = 2'b10;
         2'b11:   pick = prio ? 2'b10 : 2'b01;
         default: pick = 2'b00;
      endcase
   end

endmodule

// File: rtl/ddr2_write_arbiter.sv
// Shares the DDR2 address and write-data FIFOs between two two-beat write
// masters. One master owns both FIFOs for a whole transaction; the other is
// stalled by seeing its full flags asserted.
module ddr2_write_arbiter
   import ddr2_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int MASK_W = MASK_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] m0_af_addr_din,
   input  logic              m0_af_wr_en,
   input  logic [DATA_W-1:0] m0_wdf_din,
   input  logic [MASK_W-1:0] m0_wdf_mask_din,
   input  logic              m0_wdf_wr_en,
   input  logic [ADDR_W-1:0] m1_af_addr_din,
   input  logic              m1_af_wr_en,
   input  logic [DATA_W-1:0] m1_wdf_din,
   input  logic [MASK_W-1:0] m1_wdf_mask_din,
   input  logic              m1_wdf_wr_en,
   output logic              m0_af_full,
   output logic              m0_wdf_full,
   output logic              m1_af_full,
   output logic              m1_wdf_full,
   input  logic              af_full,
   input  logic              wdf_full,
   output logic [ADDR_W-1:0] af_addr_din,
   output logic              af_wr_en,
   output logic [DATA_W-1:0] wdf_din,
   output logic [MASK_W-1:0] wdf_mask_din,
   output logic              wdf_wr_en,
   output logic [1:0]        grant,
   output logic [15:0]       m0_xfer_cnt,
   output logic [15:0]       m1_xfer_cnt
);

   localparam logic [MASK_W-1:0] MASK_IDLE = '1;

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic              prio;
   logic [1:0]        grant_q;
   logic [1:0]        pick;
   logic [15:0]       m0_cnt_q;
   logic [15:0]       m1_cnt_q;

   // Granted master's view, selected by the upper grant bit
   logic              gsel;
   logic              gm_af_wr_en;
   logic              gm_wdf_wr_en;
   logic [ADDR_W-1:0] gm_addr;
   logic [DATA_W-1:0] gm_data;
   logic [MASK_W-1:0] gm_mask;
   logic              beat1_ok;
   logic              beat2_ok;
   logic              xfer_done;

   ddr2_arb_rr u_rr (
      .req  ({m1_af_wr_en, m0_af_wr_en}),
      .prio (prio),
      .pick (pick)
   );

   assign gsel = grant_q[1];

   // Select the granted master's request, address, data and mask
   always_comb begin
      gm_af_wr_en  = m0_af_wr_en;
      gm_wdf_wr_en = m0_wdf_wr_en;
      gm_addr      = m0_af_addr_din;
      gm_data      = m0_wdf_din;
      gm_mask      = m0_wdf_mask_din;
      if (gsel) begin
         gm_af_wr_en  = m1_af_wr_en;
         gm_wdf_wr_en = m1_wdf_wr_en;
         gm_addr      = m1_af_addr_din;
         gm_data      = m1_wdf_din;
         gm_mask      = m1_wdf_mask_din;
      end
   end

   // The address beat needs room in both FIFOs; the data beat only in wdf
   assign beat1_ok  = gm_af_wr_en & gm_wdf_wr_en & ~af_full & ~wdf_full;
   assign beat2_ok  = gm_wdf_wr_en & ~wdf_full;
   assign xfer_done = (state == BEAT2) && beat2_ok;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: arbitrate in IDLE, then walk the two beats of the winner
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick != 2'b00) state_nxt = BEAT1;
         BEAT1:   if (beat1_ok)      state_nxt = BEAT2;
         BEAT2:   if (beat2_ok)      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: forward the granted master, hold everything else at idle values
   always_comb begin
      af_wr_en     = 1'b0;
      wdf_wr_en    = 1'b0;
      af_addr_din  = '0;
      wdf_din      = '0;
      wdf_mask_din = MASK_IDLE;
      m0_af_full   = 1'b1;
      m0_wdf_full  = 1'b1;
      m1_af_full   = 1'b1;
      m1_wdf_full  = 1'b1;
      if (state == BEAT1 || state == BEAT2) begin
         af_addr_din  = gm_addr;
         wdf_din      = gm_data;
         wdf_mask_din = gm_mask;
         if (gsel) begin
            m1_af_full  = af_full;
            m1_wdf_full = wdf_full;
         end else begin
            m0_af_full  = af_full;
            m0_wdf_full = wdf_full;
         end
         if (state == BEAT1) begin
            af_wr_en  = beat1_ok;
            wdf_wr_en = beat1_ok;
         end else begin
            wdf_wr_en = beat2_ok;
         end
      end
   end

   // Grant is latched at arbitration; the finishing port loses priority
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q <= 2'b00;
         prio    <= 1'b0;
      end else if (state == IDLE) begin
         grant_q <= pick;
      end else if (xfer_done) begin
         grant_q <= 2'b00;
         prio    <= ~gsel;
      end
   end

   // Completed-transaction counters, free-running with natural wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         m0_cnt_q <= 16'd0;
         m1_cnt_q <= 16'd0;
      end else if (xfer_done) begin
         if (gsel) m1_cnt_q <= m1_cnt_q + 16'd1;
         else      m0_cnt_q <= m0_cnt_q + 16'd1;
      end
   end

   assign grant       = grant_q;
   assign m0_xfer_cnt = m0_cnt_q;
   assign m1_xfer_cnt = m1_cnt_q;

endmodule

// File: doc/ddr2_write_arbiter.md
# ddr2_write_arbiter

Shares the single DDR2 address FIFO (af) and write-data FIFO (wdf) between two write masters: port 0, the frame filler, and port 1, the line/pixel engine. Each master issues two-beat write transactions. The first beat carries the address (af_wr_en and wdf_wr_en together); the second beat carries data only. The arbiter grants one master at a time using round-robin order and never interleaves beats from different masters. Non-granted masters are stalled by presenting their full flags as asserted. The block sits between the masters and the DDR2 controller FIFO inputs.

## Interface
- ADDR_W, 31, af address width
- DATA_W, 128, wdf data width
- MASK_W, 16, wdf byte-mask width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- m0_af_addr_din / m1_af_addr_din  in  ADDR_W  master address
- m0_af_wr_en / m1_af_wr_en  in  1  master address write request; also serves as the transaction request
- m0_wdf_din / m1_wdf_din  in  DATA_W  master write data
- m0_wdf_mask_din / m1_wdf_mask_din  in  MASK_W  master byte mask
- m0_wdf_wr_en / m1_wdf_wr_en  in  1  master data write
- m0_af_full, m1_af_full  out  1  af full as seen by each master
- m0_wdf_full, m1_wdf_full  out  1  wdf full as seen by each master
- af_full, wdf_full  in  1  DDR2 FIFO full flags
- af_addr_din  out  ADDR_W; af_wr_en  out  1  to DDR2 af
- wdf_din  out  DATA_W; wdf_mask_din  out  MASK_W; wdf_wr_en  out  1  to DDR2 wdf
- grant  out  2  one-hot current grant; 2'b00 when idle
- m0_xfer_cnt, m1_xfer_cnt  out  16  completed transactions per port; wraps at 16'hFFFF→0

## Operation
- States:
  - IDLE
  - BEAT1: the address beat is pending
  - BEAT2: the second data beat is pending
- Reset values:
  - state=IDLE, prio=0 (port 0 favoured), grant=0, both counters 0
  - af_wr_en=0, wdf_wr_en=0, af_addr_din=0, wdf_din=0, wdf_mask_din=all ones
  - all m*_full=1
- IDLE:
  - All m*_full are held at 1 and nothing is forwarded.
  - A request is mN_af_wr_en=1.
  - If exactly one master requests, that master is granted.
  - If both request, the master equal to prio is granted.
  - Next state is BEAT1 with grant registered.
  - If neither requests, the arbiter stays in IDLE.
- BEAT1 and BEAT2, granted master g:
  - The granted master's mg_af_full and mg_wdf_full follow af_full and wdf_full combinationally.
  - The other master sees both full flags at 1.
  - Its addr, data and mask are muxed to the outputs.
  - Outputs not driven by g hold their idle values.
- BEAT1:
  - af_wr_en = wdf_wr_en = mg_af_wr_en & mg_wdf_wr_en & !af_full & !wdf_full.
  - When both are 1, the beat is accepted and the next state is BEAT2.
  - Otherwise the arbiter stays in BEAT1.
- BEAT2:
  - af_wr_en=0.
  - wdf_wr_en = mg_wdf_wr_en & !wdf_full.
  - When wdf_wr_en=1: next state is IDLE, grant clears, prio becomes ~g, and mg_xfer_cnt increments.
- Beats are never split across masters. A master that withdraws its request mid-transaction holds the grant indefinitely; there is no timeout. This is a master protocol violation.
- The DDR2 FIFOs never see a write while their full flag is asserted.

## Timing
- Arbitration latency is 1 cycle: a request in IDLE at cycle N makes grant valid at N+1. The earliest af_wr_en is at N+1.
- Full/data forwarding within a grant is purely combinational, with zero added latency.
- Minimum transaction length is 3 cycles (IDLE, BEAT1, BEAT2). The back-to-back rate is one transaction per 3 cycles.
- Under continuous contention, grants strictly alternate 0,1,0,1.
- rst asserted in BEAT1 or BEAT2:
  - The next cycle is the reset state.
  - The partial transaction is abandoned; the masters are reset by the same rst.
- Full rising in the same cycle as a beat: the beat is not accepted and the state holds.

## Structure
- Package ddr2_arb_pkg contains:
  - the state enum (IDLE, BEAT1, BEAT2)
  - the MASK_ALL constant
  - the default widths
- Sub-module ddr2_arb_rr is the 2-way round-robin picker. Its inputs are req[1:0] and prio; its output is a one-hot pick. It is combinational.
- The counters, FSM and muxes live in the top module.

## Test plan
- Single master: m0 issues one transaction with addr=31'h100 and no full flags. Required:
  - grant=01 for 2 cycles
  - af_wr_en=1 exactly once, with af_addr_din=31'h100
  - wdf_wr_en=1 twice
  - m0_xfer_cnt=1
- Contention: both masters request continuously for 10 transactions. Required:
  - grant sequence 01,10,01,… starting with port 0
  - beats never interleaved
  - each counter reaches 5
- Backpressure:
  - af_full=1 during BEAT1 for 4 cycles: af_wr_en stays 0 and the state holds; the beat is accepted on the cycle after af_full drops.
  - wdf_full=1 in BEAT2: wdf_wr_en stays 0 until it drops.
- Stall of the loser: while m0 is granted, m1_af_full=1 and m1_wdf_full=1 every cycle, and no m1 data appears on the outputs.
- Reset mid-BEAT2: the cycle after rst, all outputs match the reset values, the counters are 0, and the next request is granted to port 0.
- Counter wrap: preload m1_xfer_cnt to 16'hFFFF via repeated transactions; one more transaction gives 0.
